// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_pkg
// Description : Shared types and constants for the SPI serial-clock generator.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

  localparam int c_def_div_w = 8;
  localparam int c_def_cnt_w = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // SPI modes encoded as {cpol, cpha}
  localparam logic [1:0] c_mode0 = 2'b00;
  localparam logic [1:0] c_mode1 = 2'b01;
  localparam logic [1:0] c_mode2 = 2'b10;
  localparam logic [1:0] c_mode3 = 2'b11;

endpackage
`default_nettype wire

// File: rtl/spi_half_div.sv
`default_nettype none
// ============================================================================
// Module      : spi_half_div
// Description : Half-period counter; terminal count when the count equals limit.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_half_div #(
  parameter int DIV_W = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             clear_i,
  input  logic [DIV_W-1:0] limit_i,
  output logic             tc_o
);

  logic [DIV_W-1:0] r_cnt;

  assign tc_o = (r_cnt == limit_i);

  // Wraps to zero on terminal count so back-to-back periods need no clear.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_cnt <= '0;
    end else if (clear_i || tc_o) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + DIV_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/spi_sclk_gen.sv
`default_nettype none
// ============================================================================
// Module      : spi_sclk_gen
// Description : Registered SPI SCLK generator with CPOL/CPHA, strobes, CS hold.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_sclk_gen
  import spi_pkg::*;
#(
  parameter int DIV_W = c_def_div_w,
  parameter int CNT_W = c_def_cnt_w
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             cpol_i,
  input  logic             cpha_i,
  input  logic [DIV_W-1:0] clk_div_i,
  input  logic [CNT_W-1:0] nbits_i,
  output logic             sclk_o,
  output logic             sample_o,
  output logic             shift_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int c_ec_w = CNT_W + 1;

  state_t            r_state;
  logic              r_cpol;
  logic              r_cpha;
  logic [DIV_W-1:0]  r_div;
  logic [CNT_W-1:0]  r_nbits;
  logic [c_ec_w-1:0] r_ec;
  logic              r_sclk;
  logic              r_sample;
  logic              r_shift;
  logic              r_busy;
  logic              r_done;

  logic              w_tc;
  logic              w_clear;
  logic              w_lead;
  logic              w_last;
  logic [c_ec_w-1:0] w_ec_next;

  assign w_clear   = (r_state == ST_IDLE) || abort_i;
  assign w_ec_next = r_ec + c_ec_w'(1);
  assign w_lead    = w_ec_next[0];
  assign w_last    = (w_ec_next == {r_nbits, 1'b0});

  spi_half_div #(
    .DIV_W (DIV_W)
  ) u_half_div (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (w_clear),
    .limit_i (r_div),
    .tc_o    (w_tc)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state  <= ST_IDLE;
      r_cpol   <= 1'b0;
      r_cpha   <= 1'b0;
      r_div    <= '0;
      r_nbits  <= '0;
      r_ec     <= '0;
      r_sclk   <= 1'b0;
      r_sample <= 1'b0;
      r_shift  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_sample <= 1'b0;
      r_shift  <= 1'b0;
      r_done   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_sclk <= cpol_i;
          if (start_i && !abort_i) begin
            r_cpol  <= cpol_i;
            r_cpha  <= cpha_i;
            r_div   <= clk_div_i;
            r_nbits <= nbits_i;
            r_ec    <= '0;
            r_busy  <= 1'b1;
            r_state <= (nbits_i == '0) ? ST_HOLD : ST_RUN;
          end
        end
        ST_RUN: begin
          if (abort_i) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_sclk  <= r_cpol;
          end else if (w_tc) begin
            r_sclk <= ~r_sclk;
            r_ec   <= w_ec_next;
            // The first MOSI bit is pre-driven in CPHA=0, so the final trailing edge shifts nothing.
            if (r_cpha) begin
              r_shift  <= w_lead;
              r_sample <= !w_lead;
            end else begin
              r_sample <= w_lead;
              r_shift  <= !w_lead && !w_last;
            end
            if (w_last) begin
              r_state <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (abort_i) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_sclk  <= r_cpol;
          end else if (w_tc) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign sclk_o   = r_sclk;
  assign sample_o = r_sample;
  assign shift_o  = r_shift;
  assign busy_o   = r_busy;
  assign done_o   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_spi_sclk_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_sclk_gen
// Description : Self-checking bench for spi_sclk_gen (timing model + directed vectors).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_sclk_gen;
  import spi_pkg::*;

  localparam int DIV_W = 8;
  localparam int CNT_W = 6;

  logic             clk_i = 1'b0;
  logic             reset_i;
  logic             start_i = 1'b0;
  logic             abort_i = 1'b0;
  logic             cpol_i = 1'b0;
  logic             cpha_i = 1'b0;
  logic [DIV_W-1:0] clk_div_i = '0;
  logic [CNT_W-1:0] nbits_i = '0;
  logic             sclk_o, sample_o, shift_o, busy_o, done_o;

  int checks = 0;
  int errors = 0;
  int rel = 0;
  bit cmp_en = 1'b0;

  // Expected vector {sclk, sample, shift, busy, done}
  logic [4:0] exp_v = '0;
  bit m_act = 1'b0, m_cpol = 1'b0, m_cpha = 1'b0, edge_now = 1'b0;
  int m_r = 0, m_div = 0, m_nb = 0, p = 1, tot = 0, j = 0, e = 0;

  always #5 clk_i = ~clk_i;

  spi_sclk_gen #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .start_i   (start_i),
    .abort_i   (abort_i),
    .cpol_i    (cpol_i),
    .cpha_i    (cpha_i),
    .clk_div_i (clk_div_i),
    .nbits_i   (nbits_i),
    .sclk_o    (sclk_o),
    .sample_o  (sample_o),
    .shift_o   (shift_o),
    .busy_o    (busy_o),
    .done_o    (done_o)
  );

  // Timing model: outputs derived from the elapsed cycles r since start acceptance.
  always begin
    @(posedge clk_i or posedge reset_i);
    if (reset_i) begin
      m_act = 1'b0;
      exp_v = '0;
    end else if (!m_act) begin
      exp_v = {cpol_i, 4'b0000};
      if (start_i && !abort_i) begin
        m_act = 1'b1; m_r = 0;
        m_cpol = cpol_i; m_cpha = cpha_i;
        m_div = int'(clk_div_i); m_nb = int'(nbits_i);
        exp_v[1] = 1'b1;
      end
    end else begin
      m_r = m_r + 1;
      if (abort_i) begin
        m_act = 1'b0;
        exp_v = {m_cpol, 4'b0000};
      end else begin
        p = m_div + 1;
        tot = (2 * m_nb + 1) * p;
        j = m_r / p;
        e = (j > 2 * m_nb) ? 2 * m_nb : j;
        edge_now = (m_r % p == 0) && (j >= 1) && (j <= 2 * m_nb);
        exp_v[4] = m_cpol ^ (e % 2 == 1);
        exp_v[3] = edge_now && (m_cpha ? (j % 2 == 0) : (j % 2 == 1));
        exp_v[2] = edge_now && (m_cpha ? (j % 2 == 1) : ((j % 2 == 0) && (j != 2 * m_nb)));
        exp_v[1] = (m_r < tot);
        exp_v[0] = (m_r == tot);
        if (m_r == tot) m_act = 1'b0;
      end
    end
  end

  always begin
    @(negedge clk_i);
    if (cmp_en) begin
      checks++;
      if ({sclk_o, sample_o, shift_o, busy_o, done_o} !== exp_v) begin
        errors++;
        $display("FAIL model_cmp t=%0t: sclk/sample/shift/busy/done got %b expected %b",
                 $time, {sclk_o, sample_o, shift_o, busy_o, done_o}, exp_v);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic adv(input int m);
    while (rel < m) begin
      @(posedge clk_i);
      rel++;
    end
    #1;
  endtask

  task automatic go(input logic [1:0] mode, input int div, input int nb);
    @(negedge clk_i);
    cpol_i = mode[1]; cpha_i = mode[0];
    clk_div_i = DIV_W'(div); nbits_i = CNT_W'(nb);
    start_i = 1'b1;
    @(posedge clk_i);
    rel = 0;
    #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done_o !== 1'b1 && n < budget) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    chk("wait_done", {31'b0, done_o}, 32'd1);
  endtask

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: simulation did not complete");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    chk("reset_vec", {27'b0, sclk_o, sample_o, shift_o, busy_o, done_o}, 32'd0);
    cmp_en = 1'b1;
    @(negedge clk_i);
    reset_i = 1'b0;
    cpol_i = 1'b1;
    @(posedge clk_i); #1;
    chk("idle_follows_cpol", {31'b0, sclk_o}, 32'd1);

    // Mode 0, div=1, nbits=2
    go(c_mode0, 1, 2);
    chk("m0_busy_k", {31'b0, busy_o}, 32'd1);
    adv(2);  chk("m0_k2", {29'b0, sclk_o, sample_o, shift_o}, 32'b110);
    adv(4);  chk("m0_k4", {29'b0, sclk_o, sample_o, shift_o}, 32'b001);
    adv(6);  chk("m0_k6", {29'b0, sclk_o, sample_o, shift_o}, 32'b110);
    adv(8);  chk("m0_k8", {29'b0, sclk_o, sample_o, shift_o}, 32'b000);
    adv(9);  chk("m0_k9", {30'b0, busy_o, done_o}, 32'b10);
    adv(10); chk("m0_k10", {30'b0, busy_o, done_o}, 32'b01);
    adv(11); chk("m0_k11", {31'b0, done_o}, 32'd0);

    // Mode 3, div=0, nbits=1
    go(c_mode3, 0, 1);
    chk("m3_idle", {31'b0, sclk_o}, 32'd1);
    adv(1); chk("m3_k1", {29'b0, sclk_o, sample_o, shift_o}, 32'b001);
    adv(2); chk("m3_k2", {29'b0, sclk_o, sample_o, shift_o}, 32'b110);
    adv(3); chk("m3_k3", {30'b0, busy_o, done_o}, 32'b01);

    // nbits=0, div=3
    go(c_mode0, 3, 0);
    adv(3); chk("n0_k3", {27'b0, sclk_o, sample_o, shift_o, busy_o, done_o}, 32'b00010);
    adv(4); chk("n0_k4", {30'b0, busy_o, done_o}, 32'b01);

    // Abort during mode 0, div=1, nbits=4
    go(c_mode0, 1, 4);
    adv(3); chk("ab_pre_sclk", {31'b0, sclk_o}, 32'd1);
    abort_i = 1'b1;
    adv(4); chk("ab_k4", {30'b0, busy_o, sclk_o}, 32'b00);
    abort_i = 1'b0;
    adv(12); chk("ab_no_done", {31'b0, done_o}, 32'd0);
    go(c_mode0, 2, 3);
    chk("ab_restart_busy", {31'b0, busy_o}, 32'd1);
    wait_done(40);

    // Start and abort together in IDLE
    @(negedge clk_i);
    start_i = 1'b1; abort_i = 1'b1;
    @(posedge clk_i); #1;
    chk("start_abort_busy", {31'b0, busy_o}, 32'd0);
    start_i = 1'b0; abort_i = 1'b0;

    // Config changes mid-transfer are ignored
    go(c_mode1, 2, 3);
    adv(1);
    clk_div_i = '0; nbits_i = CNT_W'(7); cpol_i = 1'b1; cpha_i = 1'b0;
    adv(3);  chk("cfg_k3", {29'b0, sclk_o, sample_o, shift_o}, 32'b101);
    adv(6);  chk("cfg_k6", {29'b0, sclk_o, sample_o, shift_o}, 32'b010);
    adv(20); chk("cfg_k20", {30'b0, busy_o, done_o}, 32'b10);
    adv(21); chk("cfg_k21", {30'b0, busy_o, done_o}, 32'b01);

    // Asynchronous reset mid-RUN with cpol=1
    go(c_mode2, 3, 4);
    adv(8); chk("rst_pre_sclk", {31'b0, sclk_o}, 32'd1);
    #2;
    reset_i = 1'b1;
    #1;
    chk("rst_async", {30'b0, sclk_o, busy_o}, 32'b00);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b0;
    cpol_i = 1'b1;
    @(posedge clk_i); #1;
    chk("rst_release", {30'b0, sclk_o, busy_o}, 32'b10);

    repeat (4) @(posedge clk_i);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
